// File: rtl/matrix_round_ctrl.sv
// Round controller for the memory-matrix game: latches a solution, shows it for a
// fixed time, then scores single-tile presses until the pattern is found or misses run out.
module matrix_round_ctrl #(
   parameter int unsigned TILES          = 8,
   parameter int unsigned GUESS_W        = 4,
   parameter int unsigned DISPLAY_CYCLES = 100000000,
   parameter int unsigned CNT_W          = 27
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [TILES-1:0]   solution,
   input  logic [GUESS_W-1:0] max_guesses,
   input  logic [TILES-1:0]   guess,
   output logic [TILES-1:0]   board_led,
   output logic [TILES-1:0]   found,
   output logic [GUESS_W-1:0] guesses_left,
   output logic               hit,
   output logic               miss,
   output logic               round_start,
   output logic               playing,
   output logic               win,
   output logic               lose
);

   localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(DISPLAY_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START_WAIT = 3'd1,
      SHOW       = 3'd2,
      PLAY       = 3'd3,
      WIN        = 3'd4,
      LOSE       = 3'd5,
      END_WAIT   = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [TILES-1:0]   sol_q, sol_d;
   logic [TILES-1:0]   found_q, found_d;
   logic [TILES-1:0]   guess_q;
   logic [TILES-1:0]   board_led_q, board_led_d;
   logic [GUESS_W-1:0] guesses_left_q, guesses_left_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic               unlim_q, unlim_d;
   logic               hit_q, hit_d;
   logic               miss_q, miss_d;
   logic               round_start_q, round_start_d;
   logic               playing_q, win_q, lose_q;
   logic [TILES-1:0]   press;
   logic               single_press;

   // A press is a rising button edge; only exactly one new button per cycle is scored.
   assign press        = guess & ~guess_q;
   assign single_press = (press != '0) && ((press & (press - TILES'(1))) == '0);

   always_comb begin
      state_d        = state_q;
      sol_d          = sol_q;
      found_d        = found_q;
      guesses_left_d = guesses_left_q;
      timer_d        = timer_q;
      unlim_d        = unlim_q;
      hit_d          = 1'b0;
      miss_d         = 1'b0;
      round_start_d  = 1'b0;
      board_led_d    = '0;

      case (state_q)
         IDLE: begin
            if (start) state_d = START_WAIT;
         end
         START_WAIT: begin
            if (!start) begin
               state_d        = SHOW;
               sol_d          = solution;
               found_d        = '0;
               guesses_left_d = max_guesses;
               unlim_d        = (max_guesses == '0);
               timer_d        = TIMER_LOAD;
               round_start_d  = 1'b1;
            end
         end
         SHOW: begin
            if (timer_q == '0) state_d = PLAY;
            else               timer_d = timer_q - CNT_W'(1);
         end
         PLAY: begin
            if (sol_q == '0) begin
               state_d = WIN;
            end else if (single_press) begin
               if ((press & sol_q & ~found_q) != '0) begin
                  found_d = found_q | press;
                  hit_d   = 1'b1;
                  if ((found_q | press) == sol_q) state_d = WIN;
               end else if ((press & ~sol_q) != '0) begin
                  miss_d = 1'b1;
                  if (!unlim_q) begin
                     guesses_left_d = guesses_left_q - GUESS_W'(1);
                     if (guesses_left_q == GUESS_W'(1)) state_d = LOSE;
                  end
               end
            end
         end
         WIN, LOSE: begin
            if (start) state_d = END_WAIT;
         end
         END_WAIT: begin
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // LED pattern follows the state being entered so it is registered with it.
      case (state_d)
         SHOW, WIN: board_led_d = sol_d;
         PLAY:      board_led_d = found_d;
         LOSE:      board_led_d = sol_d & ~found_d;
         default:   board_led_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         sol_q          <= '0;
         found_q        <= '0;
         guess_q        <= '0;
         board_led_q    <= '0;
         guesses_left_q <= '0;
         timer_q        <= '0;
         unlim_q        <= 1'b0;
         hit_q          <= 1'b0;
         miss_q         <= 1'b0;
         round_start_q  <= 1'b0;
         playing_q      <= 1'b0;
         win_q          <= 1'b0;
         lose_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         sol_q          <= sol_d;
         found_q        <= found_d;
         guess_q        <= guess;
         board_led_q    <= board_led_d;
         guesses_left_q <= guesses_left_d;
         timer_q        <= timer_d;
         unlim_q        <= unlim_d;
         hit_q          <= hit_d;
         miss_q         <= miss_d;
         round_start_q  <= round_start_d;
         playing_q      <= (state_d == PLAY);
         win_q          <= (state_d == WIN);
         lose_q         <= (state_d == LOSE);
      end
   end

   assign board_led    = board_led_q;
   assign found        = found_q;
   assign guesses_left = guesses_left_q;
   assign hit          = hit_q;
   assign miss         = miss_q;
   assign round_start  = round_start_q;
   assign playing      = playing_q;
   assign win          = win_q;
   assign lose         = lose_q;

endmodule

// File: tb/tb_matrix_round_ctrl.sv
// Directed bench for matrix_round_ctrl with TILES=8 and a 4-cycle display time.
module tb_matrix_round_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] solution;
   logic [3:0] max_guesses;
   logic [7:0] guess;
   logic [7:0] board_led;
   logic [7:0] found;
   logic [3:0] guesses_left;
   logic       hit, miss, round_start, playing, win, lose;

   int total = 0;
   int bad   = 0;

   matrix_round_ctrl #(
      .TILES(8), .GUESS_W(4), .DISPLAY_CYCLES(4), .CNT_W(3)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .solution(solution),
      .max_guesses(max_guesses), .guess(guess), .board_led(board_led),
      .found(found), .guesses_left(guesses_left), .hit(hit), .miss(miss),
      .round_start(round_start), .playing(playing), .win(win), .lose(lose)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Press and release start; returns round_start sampled after the release edge.
   task automatic start_round(input logic [7:0] sol, input logic [3:0] mx, output logic rs);
      solution    = sol;
      max_guesses = mx;
      start = 1'b1; step();
      start = 1'b0; step();
      rs = round_start;
   endtask

   task automatic wait_show();
      repeat (4) step();
   endtask

   task automatic end_round();
      start = 1'b1; step();
      start = 1'b0; step();
   endtask

   // Press a button pattern for one cycle, capture the scoring edge, then release.
   task automatic press(input logic [7:0] v, output logic h, output logic m, output logic w, output logic l);
      guess = v; step();
      h = hit; m = miss; w = win; l = lose;
      guess = 8'h00; step();
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; solution = 8'h00; max_guesses = 4'd0; guess = 8'h00;
      step(); step();
      total++;
      if ({board_led, found, guesses_left, hit, miss, round_start, playing, win, lose} !== 29'd0) begin
         bad++; $display("FAIL reset_outputs got=%h exp=0",
            {board_led, found, guesses_left, hit, miss, round_start, playing, win, lose});
      end
      reset = 1'b1; step();
   endtask

   task automatic test_normal_win();
      logic rs, h, m, w, l;
      logic [7:0] bits [4];
      bits[0] = 8'h01; bits[1] = 8'h04; bits[2] = 8'h20; bits[3] = 8'h80;
      start_round(8'hA5, 4'd3, rs);
      total++; if (rs !== 1'b1) begin bad++; $display("FAIL norm_round_start got=%b exp=1", rs); end
      total++; if (board_led !== 8'hA5) begin bad++; $display("FAIL norm_show0 got=%h exp=a5", board_led); end
      for (int i = 1; i < 4; i++) begin
         step();
         total++;
         if (board_led !== 8'hA5 || playing !== 1'b0 || round_start !== 1'b0) begin
            bad++; $display("FAIL norm_show%0d led=%h play=%b rs=%b exp a5/0/0", i, board_led, playing, round_start);
         end
      end
      step();
      total++;
      if (playing !== 1'b1 || board_led !== 8'h00 || guesses_left !== 4'd3) begin
         bad++; $display("FAIL norm_play_entry play=%b led=%h left=%0d exp 1/00/3", playing, board_led, guesses_left);
      end
      for (int i = 0; i < 4; i++) begin
         press(bits[i], h, m, w, l);
         total++;
         if (h !== 1'b1 || m !== 1'b0 || w !== (i == 3)) begin
            bad++; $display("FAIL norm_press%0d hit=%b miss=%b win=%b exp 1/0/%0d", i, h, m, w, (i == 3));
         end
      end
      total++;
      if (found !== 8'hA5 || board_led !== 8'hA5 || win !== 1'b1 || playing !== 1'b0) begin
         bad++; $display("FAIL norm_win found=%h led=%h win=%b play=%b exp a5/a5/1/0", found, board_led, win, playing);
      end
      end_round();
      total++; if (win !== 1'b0 || board_led !== 8'h00) begin bad++; $display("FAIL norm_idle win=%b led=%h exp 0/00", win, board_led); end
   endtask

   task automatic test_loss();
      logic rs, h, m, w, l;
      start_round(8'h01, 4'd2, rs);
      wait_show();
      press(8'h02, h, m, w, l);
      total++;
      if (h !== 1'b0 || m !== 1'b1 || guesses_left !== 4'd1 || l !== 1'b0) begin
         bad++; $display("FAIL loss_miss1 hit=%b miss=%b left=%0d lose=%b exp 0/1/1/0", h, m, guesses_left, l);
      end
      press(8'h04, h, m, w, l);
      total++;
      if (m !== 1'b1 || l !== 1'b1 || guesses_left !== 4'd0 || board_led !== 8'h01) begin
         bad++; $display("FAIL loss_miss2 miss=%b lose=%b left=%0d led=%h exp 1/1/0/01", m, l, guesses_left, board_led);
      end
      end_round();
   endtask

   task automatic test_repeat_multi();
      logic rs, h, m, w, l;
      start_round(8'h03, 4'd2, rs);
      wait_show();
      press(8'h01, h, m, w, l);
      total++; if (h !== 1'b1 || found !== 8'h01) begin bad++; $display("FAIL rep_first hit=%b found=%h exp 1/01", h, found); end
      press(8'h01, h, m, w, l);
      total++;
      if (h !== 1'b0 || m !== 1'b0 || guesses_left !== 4'd2 || found !== 8'h01) begin
         bad++; $display("FAIL rep_again hit=%b miss=%b left=%0d found=%h exp 0/0/2/01", h, m, guesses_left, found);
      end
      press(8'h03, h, m, w, l);
      total++;
      if (h !== 1'b0 || m !== 1'b0 || found !== 8'h01 || w !== 1'b0) begin
         bad++; $display("FAIL rep_multi hit=%b miss=%b found=%h win=%b exp 0/0/01/0", h, m, found, w);
      end
      press(8'h02, h, m, w, l);
      total++; if (h !== 1'b1 || w !== 1'b1) begin bad++; $display("FAIL rep_win hit=%b win=%b exp 1/1", h, w); end
      end_round();
   endtask

   task automatic test_unlimited();
      logic rs, h, m, w, l;
      int misses = 0;
      int loses  = 0;
      logic [7:0] v;
      start_round(8'h80, 4'd0, rs);
      wait_show();
      for (int i = 0; i < 20; i++) begin
         v = 8'h01 << (i % 7);
         press(v, h, m, w, l);
         if (m === 1'b1) misses++;
         if (l !== 1'b0) loses++;
      end
      total++;
      if (misses != 20 || loses != 0 || guesses_left !== 4'd0 || playing !== 1'b1) begin
         bad++; $display("FAIL unlim_misses misses=%0d loses=%0d left=%0d play=%b exp 20/0/0/1", misses, loses, guesses_left, playing);
      end
      press(8'h80, h, m, w, l);
      total++; if (h !== 1'b1 || w !== 1'b1) begin bad++; $display("FAIL unlim_win hit=%b win=%b exp 1/1", h, w); end
      end_round();
   endtask

   task automatic test_held_and_zero();
      logic rs, h, m, w, l;
      int pulses = 0;
      guess = 8'h08;
      start_round(8'h08, 4'd2, rs);
      wait_show();
      for (int i = 0; i < 3; i++) begin
         if (hit !== 1'b0 || miss !== 1'b0) pulses++;
         step();
      end
      total++;
      if (pulses != 0 || playing !== 1'b1 || found !== 8'h00) begin
         bad++; $display("FAIL held_masked pulses=%0d play=%b found=%h exp 0/1/00", pulses, playing, found);
      end
      guess = 8'h00; step();
      press(8'h08, h, m, w, l);
      total++; if (h !== 1'b1 || w !== 1'b1) begin bad++; $display("FAIL held_repress hit=%b win=%b exp 1/1", h, w); end
      end_round();
      start_round(8'h00, 4'd2, rs);
      wait_show();
      total++; if (playing !== 1'b1) begin bad++; $display("FAIL zero_play got=%b exp 1", playing); end
      step();
      total++; if (win !== 1'b1 || playing !== 1'b0) begin bad++; $display("FAIL zero_win win=%b play=%b exp 1/0", win, playing); end
      end_round();
   endtask

   task automatic test_mid_reset();
      logic rs, h, m, w, l;
      start_round(8'h03, 4'd2, rs);
      wait_show();
      press(8'h01, h, m, w, l);
      total++; if (found !== 8'h01) begin bad++; $display("FAIL mid_found got=%h exp 01", found); end
      reset = 1'b0; step(); reset = 1'b1;
      total++;
      if ({board_led, found, guesses_left, playing, win, lose} !== 23'd0) begin
         bad++; $display("FAIL mid_reset led=%h found=%h left=%0d play=%b exp all 0", board_led, found, guesses_left, playing);
      end
      start_round(8'h03, 4'd2, rs);
      total++;
      if (rs !== 1'b1 || found !== 8'h00 || board_led !== 8'h03 || guesses_left !== 4'd2) begin
         bad++; $display("FAIL mid_restart rs=%b found=%h led=%h left=%0d exp 1/00/03/2", rs, found, board_led, guesses_left);
      end
   endtask

   initial begin
      test_reset();
      test_normal_win();
      test_loss();
      test_repeat_multi();
      test_unlimited();
      test_held_and_zero();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
